// File: rtl/uart_rx_pkt_ctrl.sv
// Frame controller behind the 8N1 UART receiver: parses SYNC|LEN|PAYLOAD|CSUM frames,
// buffers the payload and releases it as a valid/ready byte stream once the checksum verifies.
module uart_rx_pkt_ctrl #(
    parameter logic [7:0] SYNC_BYTE     = 8'hA5,
    parameter int         MAX_LEN       = 32,
    parameter int         AW            = 5,
    parameter int         TIMEOUT_TICKS = 2048
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_tick,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic [7:0] pkt_len,
    output logic       busy,
    output logic       csum_err,
    output logic       len_err,
    output logic       timeout_err,
    output logic       ovf_err
);

    localparam int              TW        = $clog2(TIMEOUT_TICKS);
    localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT_TICKS - 1);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      sum_q, sum_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic [7:0]      pkt_len_q, pkt_len_d;
    logic            busy_q, busy_d;
    logic            csum_err_q, csum_err_d;
    logic            len_err_q, len_err_d;
    logic            timeout_err_q, timeout_err_d;
    logic            ovf_err_q, ovf_err_d;
    logic            wr_en;
    logic [7:0]      pbuf [2**AW];

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_d       = state_q;
        len_d         = len_q;
        sum_d         = sum_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        to_cnt_d      = to_cnt_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_last_d    = out_last_q;
        pkt_len_d     = pkt_len_q;
        csum_err_d    = 1'b0;
        len_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        ovf_err_d     = 1'b0;
        wr_en         = 1'b0;

        // Inter-byte timeout; a byte on the expiring tick takes precedence.
        if (state_q == S_LEN || state_q == S_PAYLOAD || state_q == S_CSUM) begin
            if (rx_done_tick) begin
                to_cnt_d = '0;
            end else if (s_tick) begin
                if (to_cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                    to_cnt_d      = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
        end else begin
            to_cnt_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_done_tick && rx_data == SYNC_BYTE) state_d = S_LEN;
            end
            S_LEN: begin
                if (rx_done_tick) begin
                    if (rx_data != 8'd0 && rx_data <= MAX_LEN_B) begin
                        len_d    = rx_data;
                        sum_d    = rx_data;
                        wr_ptr_d = '0;
                        state_d  = S_PAYLOAD;
                    end else begin
                        len_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_done_tick) begin
                    wr_en    = 1'b1;
                    sum_d    = sum_q + rx_data;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (8'(wr_ptr_q) == len_q - 8'd1) state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (rx_done_tick) begin
                    if (rx_data == sum_q) begin
                        pkt_len_d   = len_q;
                        rd_ptr_d    = '0;
                        out_valid_d = 1'b1;
                        out_data_d  = pbuf[rd_ptr_d];
                        out_last_d  = (len_q == 8'd1);
                        state_d     = S_DRAIN;
                    end else begin
                        csum_err_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (rx_done_tick) ovf_err_d = 1'b1;
                if (out_ready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                        out_data_d = pbuf[rd_ptr_d];
                        out_last_d = (8'(rd_ptr_d) == len_q - 8'd1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            sum_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            to_cnt_q      <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            pkt_len_q     <= '0;
            busy_q        <= 1'b0;
            csum_err_q    <= 1'b0;
            len_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            ovf_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            sum_q         <= sum_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            to_cnt_q      <= to_cnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            pkt_len_q     <= pkt_len_d;
            busy_q        <= busy_d;
            csum_err_q    <= csum_err_d;
            len_err_q     <= len_err_d;
            timeout_err_q <= timeout_err_d;
            ovf_err_q     <= ovf_err_d;
        end
    end

    // NOTE: the payload buffer is deliberately not reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) pbuf[wr_ptr_q] <= rx_data;
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign pkt_len     = pkt_len_q;
    assign busy        = busy_q;
    assign csum_err    = csum_err_q;
    assign len_err     = len_err_q;
    assign timeout_err = timeout_err_q;
    assign ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: a table of whole frames with expected payload/errors,
// plus hand sequences for latency, timeout, backpressure, max length and reset.
module tb_uart_rx_pkt_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       out_ready = 1'b1;
    logic       out_valid, out_last, busy;
    logic [7:0] out_data, pkt_len;
    logic       csum_err, len_err, timeout_err, ovf_err;

    uart_rx_pkt_ctrl dut (
        .clk(clk), .rst(rst), .s_tick(s_tick), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .pkt_len(pkt_len), .busy(busy), .csum_err(csum_err), .len_err(len_err),
        .timeout_err(timeout_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Monitor: counts error pulses, collects accepted bytes, checks hold stability.
    int         n_csum, n_len, n_to, n_ovf, n_unstable;
    logic [8:0] got_q[$];
    int         acc_cyc[$];
    logic       hold_pending = 1'b0;
    logic [8:0] held;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (csum_err)    n_csum++;
            if (len_err)     n_len++;
            if (timeout_err) n_to++;
            if (ovf_err)     n_ovf++;
            if (hold_pending && (!out_valid || {out_last, out_data} != held)) n_unstable++;
            if (out_valid && out_ready) begin
                got_q.push_back({out_last, out_data});
                acc_cyc.push_back(cyc);
            end
            hold_pending = out_valid && !out_ready;
            held         = {out_last, out_data};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        step();
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
    endtask

    task automatic send_gap(input logic [7:0] b);
        send(b);
        idle(2);
    endtask

    task automatic tick();
        s_tick = 1'b1;
        step();
        s_tick = 1'b0;
        step();
    endtask

    task automatic clr();
        n_csum = 0; n_len = 0; n_to = 0; n_ovf = 0; n_unstable = 0;
        got_q.delete();
        acc_cyc.delete();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        int             nb;
        logic [0:7][7:0] b;
        int             ne;
        logic [0:3][7:0] e;
        int             ncs;
        int             nle;
        logic [7:0]     plen;
    } vec_t;

    vec_t vt[7];

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{nb:6, b:{8'hA5,8'h03,8'h10,8'h20,8'h30,8'h63,16'h0}, ne:3,
                  e:{8'h10,8'h20,8'h30,8'h00}, ncs:0, nle:0, plen:8'h03};
        vt[1] = '{nb:5, b:{8'hA5,8'h02,8'h01,8'h02,8'h00,24'h0}, ne:0,
                  e:32'h0, ncs:1, nle:0, plen:8'h03};
        vt[2] = '{nb:2, b:{8'hA5,8'h00,48'h0}, ne:0, e:32'h0, ncs:0, nle:1, plen:8'h03};
        vt[3] = '{nb:2, b:{8'hA5,8'h21,48'h0}, ne:0, e:32'h0, ncs:0, nle:1, plen:8'h03};
        vt[4] = '{nb:4, b:{8'hA5,8'h01,8'h7F,8'h80,32'h0}, ne:1,
                  e:{8'h7F,24'h0}, ncs:0, nle:0, plen:8'h01};
        vt[5] = '{nb:6, b:{8'h12,8'hA5,8'h02,8'hA5,8'hFF,8'hA6,16'h0}, ne:2,
                  e:{8'hA5,8'hFF,16'h0}, ncs:0, nle:0, plen:8'h02};
        vt[6] = '{nb:4, b:{8'hA5,8'h01,8'h55,8'h00,32'h0}, ne:0,
                  e:32'h0, ncs:1, nle:0, plen:8'h02};

        // Reset state
        clr();
        idle(3);
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pkt_len", pkt_len, 0);
        check("rst_errs", {csum_err, len_err, timeout_err, ovf_err}, 0);
        check("rst_out_data_last", {out_last, out_data}, 0);

        // Table-driven frames with out_ready held high
        for (int i = 0; i < 7; i++) begin
            clr();
            for (int k = 0; k < vt[i].nb; k++) send_gap(vt[i].b[k]);
            idle(8);
            check($sformatf("v%0d_count", i), got_q.size(), vt[i].ne);
            for (int k = 0; k < vt[i].ne; k++)
                check($sformatf("v%0d_byte%0d", i, k),
                      (k < got_q.size()) ? got_q[k] : 9'h1FF,
                      {(k == vt[i].ne - 1), vt[i].e[k]});
            check($sformatf("v%0d_csum_err", i), n_csum, vt[i].ncs);
            check($sformatf("v%0d_len_err", i), n_len, vt[i].nle);
            check($sformatf("v%0d_other_err", i), n_to + n_ovf, 0);
            check($sformatf("v%0d_busy", i), busy, 0);
            check($sformatf("v%0d_pkt_len", i), pkt_len, vt[i].plen);
        end

        // First-byte latency and back-to-back drain
        clr();
        send_gap(8'hA5); send_gap(8'h03); send_gap(8'h10); send_gap(8'h20); send_gap(8'h30);
        send(8'h63);
        check("lat_valid", out_valid, 1);
        check("lat_data", {out_last, out_data}, 9'h010);
        idle(6);
        check("b2b_count", acc_cyc.size(), 3);
        if (acc_cyc.size() == 3) begin
            check("b2b_gap1", acc_cyc[1] - acc_cyc[0], 1);
            check("b2b_gap2", acc_cyc[2] - acc_cyc[1], 1);
        end

        // Timeout expires on the 2048th tick
        clr();
        send_gap(8'hA5); send_gap(8'h02); send_gap(8'h11);
        repeat (2047) tick();
        check("to_not_yet", n_to, 0);
        check("to_busy_before", busy, 1);
        s_tick = 1'b1;
        step();
        s_tick = 1'b0;
        check("to_pulse", timeout_err, 1);
        step();
        check("to_pulse_width", timeout_err, 0);
        check("to_busy_after", busy, 0);
        check("to_count", n_to, 1);
        clr();
        send_gap(8'hA5); send_gap(8'h01); send_gap(8'h05); send_gap(8'h06);
        idle(4);
        check("to_next_frame", (got_q.size() == 1) ? got_q[0] : 9'h1FF, 9'h105);

        // Byte on the expiring tick wins
        clr();
        send_gap(8'hA5); send_gap(8'h02); send_gap(8'h11);
        repeat (2047) tick();
        s_tick = 1'b1;
        send(8'h22);
        s_tick = 1'b0;
        check("race_no_to", timeout_err, 0);
        check("race_busy", busy, 1);
        idle(2);
        send_gap(8'h35);
        idle(4);
        check("race_to_count", n_to, 0);
        check("race_count", got_q.size(), 2);
        check("race_b0", (got_q.size() > 0) ? got_q[0] : 9'h1FF, 9'h011);
        check("race_b1", (got_q.size() > 1) ? got_q[1] : 9'h1FF, 9'h122);

        // Backpressure with an overflowing byte
        clr();
        out_ready = 1'b0;
        send_gap(8'hA5); send_gap(8'h02); send_gap(8'h44); send_gap(8'h55); send_gap(8'h9B);
        idle(3);
        send(8'h77);
        idle(4);
        check("bp_valid", out_valid, 1);
        check("bp_hold", {out_last, out_data}, 9'h044);
        check("bp_busy", busy, 1);
        check("bp_none_taken", got_q.size(), 0);
        check("bp_ovf", n_ovf, 1);
        out_ready = 1'b1;
        idle(4);
        check("bp_stable", n_unstable, 0);
        check("bp_count", got_q.size(), 2);
        check("bp_b0", (got_q.size() > 0) ? got_q[0] : 9'h1FF, 9'h044);
        check("bp_b1", (got_q.size() > 1) ? got_q[1] : 9'h1FF, 9'h155);
        check("bp_idle", busy, 0);

        // Maximum length frame (32 bytes) exercises buffer wrap
        clr();
        begin
            logic [7:0] sum;
            sum = 8'h20;
            send_gap(8'hA5); send_gap(8'h20);
            for (int k = 0; k < 32; k++) begin
                send_gap(8'(k * 7 + 3));
                sum = sum + 8'(k * 7 + 3);
            end
            send_gap(sum);
        end
        idle(40);
        check("max_count", got_q.size(), 32);
        for (int k = 0; k < 32; k++)
            if (k < got_q.size())
                check($sformatf("max_b%0d", k), got_q[k], {(k == 31), 8'(k * 7 + 3)});
        check("max_pkt_len", pkt_len, 8'h20);
        check("max_errs", n_csum + n_len + n_to + n_ovf, 0);

        // Reset mid-PAYLOAD, then mid-DRAIN
        clr();
        send_gap(8'hA5); send_gap(8'h03); send_gap(8'h01);
        pulse_rst();
        check("rstp_busy", busy, 0);
        check("rstp_valid", out_valid, 0);
        out_ready = 1'b0;
        send_gap(8'hA5); send_gap(8'h02); send_gap(8'h44); send_gap(8'h55); send_gap(8'h9B);
        check("rstd_pre_valid", out_valid, 1);
        pulse_rst();
        check("rstd_valid", out_valid, 0);
        check("rstd_busy", busy, 0);
        check("rstd_pkt_len", pkt_len, 0);
        out_ready = 1'b1;
        idle(2);
        send_gap(8'hA5); send_gap(8'h01); send_gap(8'h7F); send_gap(8'h80);
        idle(4);
        check("rst_errs_none", n_csum + n_len + n_to + n_ovf, 0);
        check("rst_next_count", got_q.size(), 1);
        check("rst_next_byte", (got_q.size() > 0) ? got_q[0] : 9'h1FF, 9'h17F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
